// File: rtl/cnt_share_pkg.sv
// Shared definitions for the shared-counter scheduler: op encoding, the
// pipeline stage record and the channel-index width helper.
package cnt_share_pkg;

  typedef enum logic {
    OP_INC = 1'b0,
    OP_CLR = 1'b1
  } op_e;

  // Wide enough for the largest supported channel count (16)
  localparam int CH_W_MAX = 4;

  typedef struct packed {
    logic                valid;
    op_e                 op;
    logic [CH_W_MAX-1:0] ch;
  } stage_t;

  function automatic int ch_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter
  import cnt_share_pkg::*;
#(
  parameter  int M    = 4,
  localparam int CH_W = ch_width(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [M-1:0]    req,
  input  logic            en,
  output logic [M-1:0]    gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_idx;
  logic [CH_W-1:0] w_winner;
  logic            w_found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    w_idx    = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < M; i++) begin
      w_idx = CH_W'((int'(r_ptr) + i) % M);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    if (en && w_found) begin
      gnt[w_winner] = 1'b1;
      gnt_idx       = w_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (int'(w_winner) == M - 1) ? '0 : w_winner + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_share_sched.sv
// M per-channel counters sharing one two-stage increment pipeline; the
// operand is forwarded from the write stage so back-to-back ops count exactly.
module cnt_share_sched
  import cnt_share_pkg::*;
#(
  parameter  int N    = 17,
  parameter  int M    = 4,
  localparam int CH_W = ch_width(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [M-1:0]    req_valid,
  output logic [M-1:0]    req_ready,
  input  logic            clr_valid,
  input  logic [CH_W-1:0] clr_ch,
  input  logic [CH_W-1:0] rd_ch,
  output logic [N-1:0]    rd_cnt,
  output logic            cout_valid,
  output logic [CH_W-1:0] cout_ch
);

  logic            w_arbEn;
  logic [M-1:0]    w_gnt;
  logic [CH_W-1:0] w_gntIdx;

  stage_t          r_stageA;
  stage_t          r_stageB;
  logic [N-1:0]    r_operandB;
  logic [N-1:0]    r_bank [M];
  logic            r_coutValid;
  logic [CH_W-1:0] r_coutCh;

  stage_t          w_accept;
  logic [CH_W-1:0] w_aCh;
  logic [CH_W-1:0] w_bCh;
  logic            w_aInRange;
  logic            w_bInRange;
  logic            w_carry;
  logic [N-1:0]    w_incSum;
  logic [N-1:0]    w_writeVal;
  logic [N-1:0]    w_operand;

  assign w_arbEn = ~clr_valid & ~reset;

  rr_arbiter #(.M(M)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (w_arbEn),
    .gnt     (w_gnt),
    .gnt_idx (w_gntIdx)
  );

  assign req_ready = w_gnt;

  // A clear pre-empts the arbiter; out-of-range clears never enter the pipe
  always_comb begin
    w_accept = '0;
    if (clr_valid) begin
      w_accept.valid = (int'(clr_ch) < M);
      w_accept.op    = OP_CLR;
      w_accept.ch    = CH_W_MAX'(clr_ch);
    end else begin
      w_accept.valid = |w_gnt;
      w_accept.op    = OP_INC;
      w_accept.ch    = CH_W_MAX'(w_gntIdx);
    end
  end

  assign w_aCh      = r_stageA.ch[CH_W-1:0];
  assign w_bCh      = r_stageB.ch[CH_W-1:0];
  assign w_aInRange = (int'(r_stageA.ch) < M);
  assign w_bInRange = (int'(r_stageB.ch) < M);

  assign {w_carry, w_incSum} = {1'b0, r_operandB} + (N+1)'(1);
  assign w_writeVal = (r_stageB.op == OP_CLR) ? '0 : w_incSum;

  // Stage A reads the value being written this edge when it targets the same channel
  always_comb begin
    w_operand = '0;
    if (r_stageB.valid && w_bInRange && (w_bCh == w_aCh)) begin
      w_operand = w_writeVal;
    end else if (w_aInRange) begin
      w_operand = r_bank[w_aCh];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stageA    <= '0;
      r_stageB    <= '0;
      r_operandB  <= '0;
      r_coutValid <= 1'b0;
      r_coutCh    <= '0;
      for (int i = 0; i < M; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_stageA    <= w_accept;
      r_stageB    <= r_stageA;
      r_operandB  <= w_operand;
      r_coutValid <= r_stageB.valid && (r_stageB.op == OP_INC) && w_carry;
      if (r_stageB.valid && (r_stageB.op == OP_INC) && w_carry) begin
        r_coutCh <= w_bCh;
      end
      if (r_stageB.valid && w_bInRange) begin
        r_bank[w_bCh] <= w_writeVal;
      end
    end
  end

  assign rd_cnt     = (int'(rd_ch) < M) ? r_bank[rd_ch] : '0;
  assign cout_valid = r_coutValid;
  assign cout_ch    = r_coutCh;

endmodule
